// File: rtl/div_issue_sched.sv
// Shared iterative divider for the two EX1 issue lanes.
// Serialises lane requests and holds results until EX2 accepts.
module div_issue_sched #(
  parameter int XLEN       = 32,
  parameter bit EARLY_ZERO = 1'b1
) (
  input  logic            clk,
  input  logic            aresetn,
  input  logic            flush,
  input  logic            req0,
  input  logic            req1,
  input  logic [1:0]      op0,
  input  logic [1:0]      op1,
  input  logic [XLEN-1:0] a0,
  input  logic [XLEN-1:0] a1,
  input  logic [XLEN-1:0] b0,
  input  logic [XLEN-1:0] b1,
  input  logic            ex2_allowin,
  output logic            div_ready,
  output logic [XLEN-1:0] res0,
  output logic [XLEN-1:0] res1,
  output logic            res0_valid,
  output logic            res1_valid,
  output logic            busy
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  typedef enum logic [2:0] {
    IDLE, PREP, CALC, FIX, DONE
  } state_t;

  state_t          state;
  logic            lane;
  logic            pend1;
  logic            is_rem;
  logic            sign_q;
  logic            sign_r;
  logic            bzero;
  logic [XLEN-1:0] dvd;
  logic [XLEN-1:0] dsr;
  logic [XLEN-1:0] rem;
  logic [CW-1:0]   cnt;

  logic [1:0]      op_s;
  logic [XLEN-1:0] a_s;
  logic [XLEN-1:0] b_s;
  logic            sgn_s;
  logic [XLEN-1:0] a_abs;
  logic [XLEN-1:0] b_abs;
  logic            b_zero;
  logic [XLEN-1:0] ez_res;

  logic [XLEN:0]   rem_sh;
  logic [XLEN:0]   diff;
  logic            ge;
  logic [XLEN-1:0] rem_nx;
  logic [XLEN-1:0] quo_nx;
  logic [XLEN-1:0] q_fin;
  logic [XLEN-1:0] r_fin;

  logic            wr_en;
  logic [XLEN-1:0] wr_data;

  // Operand select and sign conditioning for the lane being prepared
  always_comb begin
    op_s   = lane ? op1 : op0;
    a_s    = lane ? a1 : a0;
    b_s    = lane ? b1 : b0;
    sgn_s  = ~op_s[1];
    a_abs  = (sgn_s & a_s[XLEN-1]) ? -a_s : a_s;
    b_abs  = (sgn_s & b_s[XLEN-1]) ? -b_s : b_s;
    b_zero = (b_s == '0);
    ez_res = op_s[0] ? a_s : '1;
  end

  // One restoring shift-subtract step plus final sign fix-up
  always_comb begin
    rem_sh = {rem, dvd[XLEN-1]};
    diff   = rem_sh - {1'b0, dsr};
    ge     = (rem_sh >= {1'b0, dsr});
    rem_nx = ge ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
    quo_nx = {dvd[XLEN-2:0], ge};
    q_fin  = bzero ? '1 : (sign_q ? -quo_nx : quo_nx);
    r_fin  = sign_r ? -rem_nx : rem_nx;
  end

  // Result write happens on entry to FIX so the lane is valid during FIX
  always_comb begin
    wr_en   = 1'b0;
    wr_data = '0;
    if (state == PREP && b_zero && EARLY_ZERO) begin
      wr_en   = 1'b1;
      wr_data = ez_res;
    end else if (state == CALC && cnt == LAST) begin
      wr_en   = 1'b1;
      wr_data = is_rem ? r_fin : q_fin;
    end
  end

  // Scheduler FSM and divider datapath registers
  always_ff @(posedge clk) begin
    if (!aresetn || flush) begin
      state      <= IDLE;
      lane       <= 1'b0;
      pend1      <= 1'b0;
      is_rem     <= 1'b0;
      sign_q     <= 1'b0;
      sign_r     <= 1'b0;
      bzero      <= 1'b0;
      dvd        <= '0;
      dsr        <= '0;
      rem        <= '0;
      cnt        <= '0;
      res0       <= '0;
      res1       <= '0;
      res0_valid <= 1'b0;
      res1_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req0 | req1) begin
            lane  <= ~req0;
            pend1 <= req0 & req1;
            state <= PREP;
          end
        end
        PREP: begin
          if (!lane) pend1 <= req1;
          dvd    <= a_abs;
          dsr    <= b_abs;
          sign_q <= sgn_s & (a_s[XLEN-1] ^ b_s[XLEN-1]);
          sign_r <= sgn_s & a_s[XLEN-1];
          is_rem <= op_s[0];
          bzero  <= b_zero;
          rem    <= '0;
          cnt    <= '0;
          if (b_zero && EARLY_ZERO) state <= FIX;
          else state <= CALC;
        end
        CALC: begin
          rem <= rem_nx;
          dvd <= quo_nx;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= FIX;
        end
        FIX: begin
          if (!lane && pend1) begin
            lane  <= 1'b1;
            state <= PREP;
          end else begin
            state <= DONE;
          end
        end
        DONE: begin
          if (ex2_allowin) begin
            state      <= IDLE;
            lane       <= 1'b0;
            res0_valid <= 1'b0;
            res1_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
      if (wr_en) begin
        if (!lane) begin
          res0       <= wr_data;
          res0_valid <= 1'b1;
        end else begin
          res1       <= wr_data;
          res1_valid <= 1'b1;
        end
      end
    end
  end

  assign busy      = (state != IDLE);
  assign div_ready = (~req0 & ~req1) | (state == DONE);

endmodule

// File: tb/tb_div_issue_sched.sv
// Self-checking bench for div_issue_sched.
// Vector table, hand sequences and a random run against a reference model.
module tb_div_issue_sched;

  logic        clk = 1'b0;
  logic        aresetn;
  logic        flush;
  logic        req0, req1;
  logic [1:0]  op0, op1;
  logic [31:0] a0, a1, b0, b1;
  logic        ex2_allowin;
  logic        div_ready;
  logic [31:0] res0, res1;
  logic        res0_valid, res1_valid;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  logic [31:0] m_res0 = '0;
  logic [31:0] m_res1 = '0;

  typedef struct {
    logic        r0;
    logic [1:0]  o0;
    logic [31:0] x0;
    logic [31:0] y0;
    logic        r1;
    logic [1:0]  o1;
    logic [31:0] x1;
    logic [31:0] y1;
    logic [31:0] e0;
    logic [31:0] e1;
    int          lat;
  } vec_t;

  div_issue_sched dut (
    .clk(clk), .aresetn(aresetn), .flush(flush),
    .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .a0(a0), .a1(a1), .b0(b0), .b1(b1),
    .ex2_allowin(ex2_allowin), .div_ready(div_ready),
    .res0(res0), .res1(res1),
    .res0_valid(res0_valid), .res1_valid(res1_valid),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_div(input logic [1:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] q, r;
    if (b == 0) begin
      q = '1;
      r = a;
    end else if (op[1]) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = a;
      r = '0;
    end else begin
      q = 32'($signed(a) / $signed(b));
      r = 32'($signed(a) % $signed(b));
    end
    return op[0] ? r : q;
  endfunction

  function automatic int lane_cost(input logic r, input logic [31:0] b);
    if (!r) return 0;
    return (b == 0) ? 2 : 34;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // mode 0: normal handoff, mode 1: flush together with ex2_allowin
  task automatic run_bundle(input vec_t v, input int hold, input int mode);
    int c0, c1, got, f0, f1;
    logic [31:0] h0, h1;
    @(posedge clk); #1;
    req0 = v.r0; op0 = v.o0; a0 = v.x0; b0 = v.y0;
    req1 = v.r1; op1 = v.o1; a1 = v.x1; b1 = v.y1;
    c0 = lane_cost(v.r0, v.y0);
    c1 = lane_cost(v.r1, v.y1);
    got = -1; f0 = -1; f1 = -1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (res0_valid && f0 < 0) f0 = n;
      if (res1_valid && f1 < 0) f1 = n;
      if (div_ready) begin
        got = n;
        break;
      end
    end
    chk("latency", got, v.lat);
    if (got < 0) begin
      $display("FAIL timeout: div_ready never rose");
      return;
    end
    if (v.r0) begin
      chk("res0", res0, v.e0);
      chk("res0_rise", f0, c0);
      m_res0 = v.e0;
    end else begin
      chk("res0_valid_idle", res0_valid, 0);
      chk("res0_hold", res0, m_res0);
    end
    if (v.r1) begin
      chk("res1", res1, v.e1);
      chk("res1_rise", f1, c0 + c1);
      m_res1 = v.e1;
    end else begin
      chk("res1_valid_idle", res1_valid, 0);
      chk("res1_hold", res1, m_res1);
    end
    h0 = res0;
    h1 = res1;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk("stall_busy", busy, 1);
      chk("stall_ready", div_ready, 1);
      chk("stall_res0", res0, h0);
      chk("stall_res1", res1, h1);
      chk("stall_v0", res0_valid, v.r0);
    end
    ex2_allowin = 1'b1;
    if (mode == 1) flush = 1'b1;
    @(posedge clk); #1;
    ex2_allowin = 1'b0;
    flush = 1'b0;
    req0 = 1'b0;
    req1 = 1'b0;
    if (mode == 1) begin
      m_res0 = '0;
      m_res1 = '0;
    end
    @(negedge clk);
    chk("post_busy", busy, 0);
    chk("post_v0", res0_valid, 0);
    chk("post_v1", res1_valid, 0);
    chk("post_res0", res0, m_res0);
    chk("post_res1", res1, m_res1);
  endtask

  vec_t tbl[$];
  vec_t rv;

  initial begin
    aresetn = 1'b0; flush = 1'b0; ex2_allowin = 1'b0;
    req0 = 1'b0; req1 = 1'b0; op0 = '0; op1 = '0;
    a0 = '0; a1 = '0; b0 = '0; b1 = '0;

    tbl.push_back('{1, 2'b00, 32'd100, 32'd7, 0, 2'b00, 0, 0,
                    32'd14, 0, 35});
    tbl.push_back('{1, 2'b01, -32'sd7, 32'd2, 1, 2'b10, 32'hFFFF_FFFF, 32'd2,
                    32'hFFFF_FFFF, 32'h7FFF_FFFF, 69});
    tbl.push_back('{1, 2'b00, 32'd5, 32'd0, 0, 2'b00, 0, 0,
                    32'hFFFF_FFFF, 0, 3});
    tbl.push_back('{1, 2'b11, 32'd5, 32'd0, 0, 2'b00, 0, 0,
                    32'd5, 0, 3});
    tbl.push_back('{1, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 0, 2'b00, 0, 0,
                    32'h8000_0000, 0, 35});
    tbl.push_back('{1, 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 0, 2'b00, 0, 0,
                    32'h0, 0, 35});
    tbl.push_back('{0, 2'b00, 0, 0, 1, 2'b01, -32'sd100, 32'd7,
                    0, 32'hFFFF_FFFE, 35});
    tbl.push_back('{1, 2'b00, -32'sd9, 32'd0, 1, 2'b00, 32'd100, -32'sd7,
                    32'hFFFF_FFFF, 32'hFFFF_FFF2, 37});
    tbl.push_back('{1, 2'b01, -32'sd9, 32'd0, 0, 2'b00, 0, 0,
                    32'hFFFF_FFF7, 0, 3});

    repeat (3) @(posedge clk);
    #1 aresetn = 1'b1;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_ready", div_ready, 1);
    chk("rst_v0", res0_valid, 0);
    chk("rst_v1", res1_valid, 0);
    chk("rst_res0", res0, 0);
    chk("rst_res1", res1, 0);

    foreach (tbl[i]) run_bundle(tbl[i], 0, 0);

    // flush in the middle of CALC, then a fresh request
    @(posedge clk); #1;
    req0 = 1'b1; op0 = 2'b00; a0 = 32'd100; b0 = 32'd7;
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    req0 = 1'b0;
    @(negedge clk);
    chk("flush_busy_before", busy, 1);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_busy", busy, 0);
    chk("flush_v0", res0_valid, 0);
    chk("flush_res0", res0, 0);
    m_res0 = '0;
    m_res1 = '0;
    run_bundle('{1, 2'b00, 32'd9, 32'd3, 0, 2'b00, 0, 0,
                 32'd3, 0, 35}, 0, 0);

    // EX2 back-pressure, then flush racing the handoff
    run_bundle('{1, 2'b10, 32'd1000, 32'd10, 1, 2'b11, 32'd1000, 32'd7,
                 32'd100, 32'd6, 69}, 5, 0);
    run_bundle('{1, 2'b00, 32'd42, 32'd6, 0, 2'b00, 0, 0,
                 32'd7, 0, 35}, 2, 1);

    for (int i = 0; i < 40; i++) begin
      rv.r0 = 1'($urandom_range(0, 1));
      rv.r1 = rv.r0 ? 1'($urandom_range(0, 1)) : 1'b1;
      rv.o0 = 2'($urandom_range(0, 3));
      rv.o1 = 2'($urandom_range(0, 3));
      rv.x0 = pick(); rv.y0 = pick();
      rv.x1 = pick(); rv.y1 = pick();
      rv.e0 = ref_div(rv.o0, rv.x0, rv.y0);
      rv.e1 = ref_div(rv.o1, rv.x1, rv.y1);
      rv.lat = 1 + lane_cost(rv.r0, rv.y0) + lane_cost(rv.r1, rv.y1);
      run_bundle(rv, $urandom_range(0, 2), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
